// File: rtl/lcd_timing_pkg.sv
// Shared constants, helpers and FSM encoding for the LCD timing driver.
// Default constants describe an 800x480 panel.
package lcd_timing_pkg;

    localparam logic [10:0] DEF_H_SYNC  = 11'd128;
    localparam logic [10:0] DEF_H_BACK  = 11'd88;
    localparam logic [10:0] DEF_H_DISP  = 11'd800;
    localparam logic [10:0] DEF_H_FRONT = 11'd40;
    localparam logic [10:0] DEF_V_SYNC  = 11'd2;
    localparam logic [10:0] DEF_V_BACK  = 11'd33;
    localparam logic [10:0] DEF_V_DISP  = 11'd480;
    localparam logic [10:0] DEF_V_FRONT = 11'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lcd_state_t;

    function automatic logic [10:0] axis_total(
        input logic [10:0] sync,
        input logic [10:0] back,
        input logic [10:0] disp,
        input logic [10:0] front
    );
        return sync + back + disp + front;
    endfunction

    function automatic logic [10:0] axis_active_start(
        input logic [10:0] sync,
        input logic [10:0] back
    );
        return sync + back;
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// Wrapping position counter for one scan axis (0..TOTAL-1).
// Ports: lcd_pclk, rst, clr (sync clear), inc (advance), cnt, wrap (last step).
module lcd_axis_counter #(
    parameter logic [10:0] TOTAL = 11'd1056
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [10:0] cnt,
    output logic        wrap
);

    logic at_end;

    assign at_end = (cnt == TOTAL - 11'd1);
    assign wrap   = inc && at_end;

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_end ? 11'd0 : cnt + 11'd1;
        end
    end

endmodule

// File: rtl/lcd_timing_driver.sv
// LCD panel timing generator: HSYNC/VSYNC/DE, early pixel coordinates, RGB gating.
// Ports: lcd_pclk, rst, disp_en, pixel_data in; coords, sync, de, rgb, bl, clk out.
module lcd_timing_driver
    import lcd_timing_pkg::*;
#(
    parameter logic [10:0] H_SYNC  = DEF_H_SYNC,
    parameter logic [10:0] H_BACK  = DEF_H_BACK,
    parameter logic [10:0] H_DISP  = DEF_H_DISP,
    parameter logic [10:0] H_FRONT = DEF_H_FRONT,
    parameter logic [10:0] V_SYNC  = DEF_V_SYNC,
    parameter logic [10:0] V_BACK  = DEF_V_BACK,
    parameter logic [10:0] V_DISP  = DEF_V_DISP,
    parameter logic [10:0] V_FRONT = DEF_V_FRONT
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic        disp_en,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        data_req,
    output logic        frame_start,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        lcd_clk
);

    localparam logic [10:0] H_TOTAL = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam logic [10:0] V_TOTAL = axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam logic [10:0] HA      = axis_active_start(H_SYNC, H_BACK);
    localparam logic [10:0] VA      = axis_active_start(V_SYNC, V_BACK);
    localparam logic [10:0] DE_END  = HA + H_DISP;
    // Coordinate request window leads the DE window by one pixel clock.
    localparam logic [10:0] REQ_BEG = HA - 11'd1;
    localparam logic [10:0] REQ_END = HA + H_DISP - 11'd1;
    localparam logic [10:0] V_END   = VA + V_DISP;

    lcd_state_t  state;
    logic        running;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        v_act;
    logic        h_de;
    logic        h_req;

    assign running = (state != ST_IDLE);

    lcd_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .lcd_pclk (lcd_pclk),
        .rst      (rst),
        .clr      (!running),
        .inc      (running),
        .cnt      (h_cnt),
        .wrap     (h_wrap)
    );

    lcd_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .lcd_pclk (lcd_pclk),
        .rst      (rst),
        .clr      (!running),
        .inc      (h_wrap),
        .cnt      (v_cnt),
        .wrap     (v_wrap)
    );

    // v_wrap marks the last cycle of a frame, the only point a scan may stop.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            lcd_bl <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (disp_en) begin
                        state  <= ST_RUN;
                        lcd_bl <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!disp_en) begin
                        if (v_wrap) begin
                            state  <= ST_IDLE;
                            lcd_bl <= 1'b0;
                        end else begin
                            state  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (disp_en) begin
                        state  <= ST_RUN;
                    end else if (v_wrap) begin
                        state  <= ST_IDLE;
                        lcd_bl <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    lcd_bl <= 1'b0;
                end
            endcase
        end
    end

    assign v_act = (v_cnt >= VA) && (v_cnt < V_END);
    assign h_de  = (h_cnt >= HA) && (h_cnt < DE_END);
    assign h_req = (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);

    assign lcd_hs      = !(running && (h_cnt < H_SYNC));
    assign lcd_vs      = !(running && (v_cnt < V_SYNC));
    assign lcd_de      = running && h_de && v_act;
    assign data_req    = running && h_req && v_act;
    assign frame_start = running && (h_cnt == 11'd0) && (v_cnt == 11'd0);

    assign pixel_xpos = data_req ? (h_cnt - REQ_BEG) : 11'd0;
    assign pixel_ypos = data_req ? (v_cnt - VA) : 11'd0;

    // The source registers colour one cycle after the coordinates, so the
    // data arriving now already belongs to the current DE pixel.
    assign lcd_rgb = lcd_de ? pixel_data : 24'd0;

    assign h_disp  = H_DISP;
    assign v_disp  = V_DISP;
    assign lcd_clk = lcd_pclk;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Self-checking bench for lcd_timing_driver on a reduced panel geometry.
// Scoreboard of expected pixels checked against lcd_rgb on every DE cycle.
module tb_lcd_timing_driver;

    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HD = 8;
    localparam int HF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VD = 5;
    localparam int VF = 1;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_en = 1'b0;
    logic [23:0] pixel_data = '0;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        data_req;
    logic        frame_start;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        lcd_bl;
    logic        lcd_clk;

    int n_cmp = 0;
    int n_err = 0;

    lcd_timing_driver #(
        .H_SYNC (11'(HS)), .H_BACK (11'(HB)),
        .H_DISP (11'(HD)), .H_FRONT(11'(HF)),
        .V_SYNC (11'(VS)), .V_BACK (11'(VB)),
        .V_DISP (11'(VD)), .V_FRONT(11'(VF))
    ) dut (
        .lcd_pclk   (clk),
        .rst        (rst),
        .disp_en    (disp_en),
        .pixel_data (pixel_data),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .data_req   (data_req),
        .frame_start(frame_start),
        .lcd_hs     (lcd_hs),
        .lcd_vs     (lcd_vs),
        .lcd_de     (lcd_de),
        .lcd_rgb    (lcd_rgb),
        .lcd_bl     (lcd_bl),
        .lcd_clk    (lcd_clk)
    );

    always #5 clk = ~clk;

    // Pixel source: colour registered one cycle after the coordinates.
    always @(posedge clk) begin
        pixel_data <= {pixel_ypos[7:0], pixel_xpos, 5'd0};
    end

    task automatic test_reset();
        rst = 1'b1;
        disp_en = 1'b0;
        #1;
        n_cmp++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl,
             lcd_rgb, pixel_xpos, pixel_ypos} !== {6'b110000, 24'd0, 22'd0}) begin
            n_err++;
            $display("FAIL reset_vals got hs%b vs%b de%b rq%b fs%b bl%b rgb%h x%0d y%0d",
                     lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl,
                     lcd_rgb, pixel_xpos, pixel_ypos);
        end
        n_cmp++;
        if (h_disp !== 11'(HD) || v_disp !== 11'(VD)) begin
            n_err++;
            $display("FAIL disp_consts got %0d/%0d want %0d/%0d", h_disp, v_disp, HD, VD);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rgb} !== {4'b1100, 24'd0}) begin
                n_err++;
                $display("FAIL idle_hold c%0d got hs%b vs%b de%b bl%b rgb%h want 1 1 0 0 0",
                         i, lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rgb);
            end
        end
    endtask

    task automatic test_scan();
        logic [23:0] sb[$];
        logic [23:0] exp_rgb;
        logic [23:0] first_rgb;
        logic [23:0] last_rgb;
        int n_de;
        n_de = 0;
        first_rgb = 24'hFFFFFF;
        last_rgb = 24'hFFFFFF;
        disp_en = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            int h, v, ex, ey;
            logic ehs, evs, ede, erq, efs, vact;
            @(negedge clk);
            h = c % HT;
            v = (c / HT) % VT;
            vact = (v >= VA) && (v < VA + VD);
            ehs = !(h < HS);
            evs = !(v < VS);
            ede = vact && (h >= HA) && (h < HA + HD);
            erq = vact && (h >= HA - 1) && (h < HA + HD - 1);
            efs = (h == 0) && (v == 0);
            ex = erq ? h - (HA - 1) : 0;
            ey = erq ? v - VA : 0;
            n_cmp++;
            if ({lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl,
                 pixel_xpos, pixel_ypos} !==
                {ehs, evs, ede, erq, efs, 1'b1, 11'(ex), 11'(ey)}) begin
                n_err++;
                $display("FAIL scan h%0d v%0d got hs%b vs%b de%b rq%b fs%b bl%b x%0d y%0d want hs%b vs%b de%b rq%b fs%b bl1 x%0d y%0d",
                         h, v, lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl,
                         pixel_xpos, pixel_ypos, ehs, evs, ede, erq, efs, ex, ey);
            end
            if (erq) sb.push_back({8'(ey), 11'(ex), 5'd0});
            if (lcd_de) begin
                n_de++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty h%0d v%0d got rgb %h want queued pixel", h, v, lcd_rgb);
                end else begin
                    exp_rgb = sb.pop_front();
                    if (lcd_rgb !== exp_rgb) begin
                        n_err++;
                        $display("FAIL rgb h%0d v%0d got %h want %h", h, v, lcd_rgb, exp_rgb);
                    end
                end
                if (n_de == 1) first_rgb = lcd_rgb;
                last_rgb = lcd_rgb;
            end
        end
        n_cmp++;
        if (n_de != 2 * HD * VD || sb.size() != 0) begin
            n_err++;
            $display("FAIL de_count got %0d left %0d want %0d left 0", n_de, sb.size(), 2 * HD * VD);
        end
        n_cmp++;
        if (first_rgb !== 24'd0 || last_rgb !== {8'(VD - 1), 11'(HD - 1), 5'd0}) begin
            n_err++;
            $display("FAIL first_last got %h/%h want %h/%h", first_rgb, last_rgb,
                     24'd0, {8'(VD - 1), 11'(HD - 1), 5'd0});
        end
    endtask

    task automatic test_drain();
        int n_de;
        n_de = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if (frame_start !== 1'b1) begin
                    n_err++;
                    $display("FAIL drain_fs got %b want 1", frame_start);
                end
            end
            n_cmp++;
            if (lcd_bl !== 1'b1) begin
                n_err++;
                $display("FAIL drain_bl c%0d got %b want 1", c, lcd_bl);
            end
            if (lcd_de) n_de++;
            if (c == 3 * HT) disp_en = 1'b0;
        end
        n_cmp++;
        if (n_de != HD * VD) begin
            n_err++;
            $display("FAIL drain_de got %0d want %0d", n_de, HD * VD);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({lcd_bl, lcd_hs, lcd_vs, lcd_de, frame_start} !== 5'b01100) begin
                n_err++;
                $display("FAIL drain_idle c%0d got bl%b hs%b vs%b de%b fs%b want 0 1 1 0 0",
                         i, lcd_bl, lcd_hs, lcd_vs, lcd_de, frame_start);
            end
        end
    endtask

    task automatic test_drain_resume();
        int n_fs;
        n_fs = 0;
        disp_en = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (frame_start) n_fs++;
            n_cmp++;
            if (lcd_bl !== 1'b1) begin
                n_err++;
                $display("FAIL resume_bl c%0d got %b want 1", c, lcd_bl);
            end
            if (c == 2 * HT) disp_en = 1'b0;
            if (c == 60) disp_en = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        if (n_fs != 1 || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL resume_fs got pulses %0d next %b want 1 1", n_fs, frame_start);
        end
    endtask

    task automatic test_reset_mid();
        repeat (6 * HT + 8) @(negedge clk);
        n_cmp++;
        if (lcd_de !== 1'b1 || lcd_bl !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre got de%b bl%b want 1 1", lcd_de, lcd_bl);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl,
             lcd_rgb, pixel_xpos, pixel_ypos} !== {6'b110000, 24'd0, 22'd0}) begin
            n_err++;
            $display("FAIL mid_rst got hs%b vs%b de%b rq%b fs%b bl%b rgb%h x%0d y%0d",
                     lcd_hs, lcd_vs, lcd_de, data_req, frame_start, lcd_bl,
                     lcd_rgb, pixel_xpos, pixel_ypos);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (lcd_bl !== 1'b0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL mid_hold got bl%b fs%b want 0 0", lcd_bl, frame_start);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({frame_start, lcd_hs, lcd_vs, lcd_bl, data_req} !== 5'b10010) begin
            n_err++;
            $display("FAIL mid_restart got fs%b hs%b vs%b bl%b rq%b want 1 0 0 1 0",
                     frame_start, lcd_hs, lcd_vs, lcd_bl, data_req);
        end
    endtask

    task automatic test_frame_period();
        int cyc;
        int n_de;
        int frames;
        cyc = 0;
        n_de = 0;
        frames = 0;
        for (int i = 0; i < 3 * FRAME + 20 && frames < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_start) begin
                n_cmp++;
                if (cyc != FRAME || n_de != HD * VD) begin
                    n_err++;
                    $display("FAIL period f%0d got %0d cyc %0d de want %0d %0d",
                             frames, cyc, n_de, FRAME, HD * VD);
                end
                frames++;
                cyc = 0;
                n_de = 0;
            end
            if (lcd_de) n_de++;
        end
        n_cmp++;
        if (frames != 3) begin
            n_err++;
            $display("FAIL period_timeout got %0d frames want 3", frames);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_drain();
        test_drain_resume();
        test_reset_mid();
        test_frame_period();
        disp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_timing_driver.md
# lcd_timing_driver

Generates the LCD panel timing (HSYNC, VSYNC, DE, pixel clock passthrough) and drives the current pixel coordinates to the pixel-generation logic. The pixel-generation logic registers its colour one cycle after the coordinates. This block is the consumer of that `pixel_data`. It issues coordinates one cycle early so the registered colour lines up with DE on the panel RGB bus. It sits between the pixel source and the panel pins.

## Interface
Parameters (defaults: 800x480 panel)
- H_SYNC, 11'd128, HSYNC pulse width in pclk cycles
- H_BACK, 11'd88, horizontal back porch
- H_DISP, 11'd800, active pixels per line
- H_FRONT, 11'd40, horizontal front porch
- V_SYNC, 11'd2, VSYNC pulse width in lines
- V_BACK, 11'd33, vertical back porch
- V_DISP, 11'd480, active lines
- V_FRONT, 11'd10, vertical front porch

Ports
- lcd_pclk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- disp_en  in  1  level request to scan frames
- pixel_data  in  24  RGB888 from pixel source; valid one cycle after the matching pixel_xpos/pixel_ypos
- pixel_xpos  out  11  requested column 0..H_DISP-1, 0 when not requesting
- pixel_ypos  out  11  requested row 0..V_DISP-1, 0 when not requesting
- h_disp  out  11  constant H_DISP
- v_disp  out  11  constant V_DISP
- data_req  out  1  coordinates valid this cycle
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 while scanning
- lcd_hs  out  1  HSYNC, active low
- lcd_vs  out  1  VSYNC, active low
- lcd_de  out  1  data enable, active high
- lcd_rgb  out  24  pixel_data while lcd_de, else 0
- lcd_bl  out  1  backlight enable, high while not IDLE
- lcd_clk  out  1  lcd_pclk forwarded

## Operation
- Constants: H_TOTAL=H_SYNC+H_BACK+H_DISP+H_FRONT (1056). V_TOTAL likewise (525). HA=H_SYNC+H_BACK. VA=V_SYNC+V_BACK.
- h_cnt 0..H_TOTAL-1. It wraps to 0 and advances v_cnt. v_cnt 0..V_TOTAL-1, and wraps to 0. Both counters are 11 bit and never exceed TOTAL-1.
- FSM with three states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0 and all timing outputs inactive. Enter RUN when disp_en=1 is sampled. RUN begins next cycle with h=0, v=0.
  - RUN: counters free-run. If disp_en=0 is sampled, go to DRAIN.
  - DRAIN: counters keep running until the last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1), then go to IDLE.
  - DRAIN: if disp_en returns to 1, go back to RUN without a frame break.
- lcd_hs=0 for h_cnt<H_SYNC, when not IDLE.
- lcd_vs=0 for v_cnt<V_SYNC, when not IDLE.
- lcd_de=1 when h_cnt in [HA, HA+H_DISP) and v_cnt in [VA, VA+V_DISP).
- data_req=1 when h_cnt in [HA-1, HA+H_DISP-1), under the same vertical condition. This is the lcd_de window shifted one cycle early.
- pixel_xpos = h_cnt-(HA-1) while data_req, else 0.
- pixel_ypos = v_cnt-VA while data_req, else 0.
- lcd_rgb = lcd_de ? pixel_data : 24'd0. This path is combinational; the source register provides the one-cycle alignment.
- Reset values: state IDLE, h_cnt=v_cnt=0, lcd_hs=lcd_vs=1, lcd_de=data_req=frame_start=lcd_bl=0, lcd_rgb=0, pixel_xpos=pixel_ypos=0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). Scanning restarts from h=0,v=0 only after rst is low and disp_en is sampled high.

## Timing
- Latency from disp_en sampled high to the first frame_start: 1 cycle.
- Within a line, the first data_req is at h_cnt=HA-1 (215) with xpos=0. lcd_de first asserts at h_cnt=HA (216).
- The last data_req is at h_cnt=HA+H_DISP-2 with xpos=H_DISP-1. lcd_de deasserts at h_cnt=HA+H_DISP (1016).
- data_req per active line: exactly H_DISP cycles. data_req per frame: H_DISP*V_DISP cycles.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL*V_TOTAL cycles (554400).
- When h wraps and v wraps in the same cycle, both counters return to 0 together and frame_start asserts the next cycle.

## Structure
- Shared package lcd_timing_pkg holds:
  - the default panel constants;
  - the TOTAL/HA/VA derivation helpers;
  - the FSM state encoding.
- One sub-module, lcd_axis_counter, is instanced twice:
  - parameter TOTAL;
  - inputs clr and inc;
  - outputs cnt and wrap.
  - The horizontal instance has inc = running. The vertical instance has inc = h wrap.

## Test plan
- Reset, then hold disp_en=0 for 2000 cycles -> lcd_hs=lcd_vs=1, lcd_de=0, lcd_bl=0, lcd_rgb=0 throughout.
- disp_en=1 -> frame_start 1 cycle later. lcd_hs low for exactly 128 cycles per line. lcd_vs low for exactly 2*1056 cycles.
- Source model that registers pixel_data={ypos[7:0],xpos[10:0],5'd0} -> on every lcd_de cycle, lcd_rgb matches the expected column and row. The first DE of a frame shows x=0,y=0; the last shows x=799,y=479.
- Drop disp_en at v_cnt=100 -> the frame completes through h=1055, v=524, then state is IDLE with lcd_bl=0. No partial frame occurs.
- Assert rst at h=500, v=200 -> all outputs at reset values in the same cycle. Release rst with disp_en=1 -> a new frame starts at h=0,v=0.
- Over 3 frames, count cycles -> 554400 cycles between frame_start pulses, and 384000 lcd_de cycles per frame.
